// File: rtl/dff_non_blocking.sv
// dff_non_blocking: two-stage enabled D-flop pipeline (Clock, Reset, Enable, D -> Q1 one edge, Q2 two edges; DFF_NON_BLOCKING_EDGE_EN adds Edge = Q1 ^ Q2)
module dff_non_blocking #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2
`ifdef DFF_NON_BLOCKING_EDGE_EN
  ,
  output logic [WIDTH-1:0] Edge
`endif
);
  logic [WIDTH-1:0] q1_q, q1_d, q2_q, q2_d;
  always_comb begin
    q1_d = Enable ? D : q1_q;
    q2_d = Enable ? q1_q : q2_q;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      q1_q <= RESET_VALUE;
      q2_q <= RESET_VALUE;
    end else begin
      q1_q <= q1_d;
      q2_q <= q2_d;
    end
  end
  assign Q1 = q1_q;
  assign Q2 = q2_q;
`ifdef DFF_NON_BLOCKING_EDGE_EN
  assign Edge = q1_q ^ q2_q;
`endif
endmodule

// File: tb/tb_dff_non_blocking.sv
// tb_dff_non_blocking: table-driven and random scoreboard checks of a 1-bit and an 8-bit dff_non_blocking
module tb_dff_non_blocking;
  typedef struct {
    bit         wide;
    logic       rst;
    logic       en;
    logic [7:0] d;
    logic [7:0] e1;
    logic [7:0] e2;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst_n1 = 1'b1, en_n1 = 1'b1, d_n1 = 1'b1;
  logic       rst_w = 1'b0, en_w = 1'b0;
  logic [7:0] d_w = 8'h00;
  logic       q1_n, q2_n;
  logic [7:0] q1_w, q2_w;
`ifdef DFF_NON_BLOCKING_EDGE_EN
  logic       edge_n;
  logic [7:0] edge_w;
`endif
  int vectors = 0;
  int miscompares = 0;
  vec_t sb[$];
  vec_t tbl[$];
  logic       mn1, mn2;
  logic [7:0] mw1, mw2;
  always #10 clk = ~clk;
  dff_non_blocking u_n (
    .Clock(clk), .Reset(rst_n1), .Enable(en_n1), .D(d_n1), .Q1(q1_n), .Q2(q2_n)
`ifdef DFF_NON_BLOCKING_EDGE_EN
    , .Edge(edge_n)
`endif
  );
  dff_non_blocking #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_w (
    .Clock(clk), .Reset(rst_w), .Enable(en_w), .D(d_w), .Q1(q1_w), .Q2(q2_w)
`ifdef DFF_NON_BLOCKING_EDGE_EN
    , .Edge(edge_w)
`endif
  );
  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    if (v.wide) begin
      rst_w = v.rst; en_w = v.en; d_w = v.d; rst_n1 = 1'b0; en_n1 = 1'b0;
    end else begin
      rst_n1 = v.rst; en_n1 = v.en; d_n1 = v.d[0]; rst_w = 1'b0; en_w = 1'b0;
    end
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.wide) begin
      cmp("q1_w", q1_w, e.e1);
      cmp("q2_w", q2_w, e.e2);
`ifdef DFF_NON_BLOCKING_EDGE_EN
      cmp("edge_w", edge_w, e.e1 ^ e.e2);
`endif
    end else begin
      cmp("q1_n", {7'd0, q1_n}, e.e1);
      cmp("q2_n", {7'd0, q2_n}, e.e2);
`ifdef DFF_NON_BLOCKING_EDGE_EN
      cmp("edge_n", {7'd0, edge_n}, e.e1 ^ e.e2);
`endif
    end
  endtask
  initial begin
    tbl = '{
      '{0, 1, 1, 8'h01, 8'h00, 8'h00},
      '{0, 0, 1, 8'h00, 8'h00, 8'h00},
      '{0, 0, 1, 8'h01, 8'h01, 8'h00},
      '{0, 0, 1, 8'h00, 8'h00, 8'h01},
      '{0, 0, 1, 8'h01, 8'h01, 8'h00},
      '{0, 0, 0, 8'h00, 8'h01, 8'h00},
      '{0, 0, 0, 8'h00, 8'h01, 8'h00},
      '{0, 0, 0, 8'h00, 8'h01, 8'h00},
      '{0, 0, 1, 8'h00, 8'h00, 8'h01},
      '{0, 0, 1, 8'h01, 8'h01, 8'h00},
      '{0, 0, 1, 8'h01, 8'h01, 8'h01},
      '{0, 1, 1, 8'h01, 8'h00, 8'h00},
      '{0, 0, 1, 8'h01, 8'h01, 8'h00},
      '{0, 1, 0, 8'h01, 8'h00, 8'h00},
      '{0, 0, 0, 8'h01, 8'h00, 8'h00},
      '{0, 0, 1, 8'h01, 8'h01, 8'h00},
      '{0, 0, 1, 8'h01, 8'h01, 8'h01},
      '{1, 1, 1, 8'h3C, 8'hA5, 8'hA5},
      '{1, 0, 1, 8'h3C, 8'h3C, 8'hA5},
      '{1, 0, 1, 8'hFF, 8'hFF, 8'h3C},
      '{1, 0, 0, 8'h00, 8'hFF, 8'h3C},
      '{1, 0, 1, 8'h00, 8'h00, 8'hFF},
      '{1, 1, 0, 8'h77, 8'hA5, 8'hA5}
    };
    foreach (tbl[i]) apply(tbl[i]);
    for (int i = 0; i < 80; i++) begin
      vec_t v;
      v.wide = (i < 2) ? i[0] : 1'($urandom_range(0, 1));
      v.rst = (i < 2) || ($urandom_range(0, 9) == 0);
      v.en = $urandom_range(0, 3) != 0;
      v.d = 8'($urandom);
      if (v.wide) begin
        if (v.rst) begin mw1 = 8'hA5; mw2 = 8'hA5; end
        else if (v.en) begin mw2 = mw1; mw1 = v.d; end
        v.e1 = mw1; v.e2 = mw2;
      end else begin
        v.d = {7'd0, v.d[0]};
        if (v.rst) begin mn1 = 1'b0; mn2 = 1'b0; end
        else if (v.en) begin mn2 = mn1; mn1 = v.d[0]; end
        v.e1 = {7'd0, mn1}; v.e2 = {7'd0, mn2};
      end
      apply(v);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
